// File: rtl/iobus_pkg.sv
// Shared IOBUS UART definitions: register offsets, STATUS bit positions and TX FSM states.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package iobus_pkg;

  localparam logic [3:0] TXDATA_OFS = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;
  localparam logic [3:0] DIV_OFS    = 4'h8;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_CNT   = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } uart_tx_state_t;

  // A zero divisor would stall the bit counter, so it is promoted to 1.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/iobus_tx_fifo.sv
// Synchronous first-word-fall-through FIFO for the UART transmit path.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module iobus_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok, pop_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/iobus_uart_tx.sv
// Memory-mapped UART transmitter on the IOBUS: TXDATA/STATUS/DIV registers, TX FIFO, serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1); otherwise frames are 8N1.
module iobus_uart_tx
  import iobus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] rd_data,
  output logic        tx
);

  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] RESET_DIV = (DEFAULT_DIV == 16'd0) ? 16'd1 : DEFAULT_DIV;

  logic           sel, wr_txdata, wr_status, wr_div;
  logic [3:0]     ofs;
  logic [15:0]    div_reg;
  logic           ovf_reg;
  logic           fifo_full, fifo_empty, fifo_pop;
  logic [7:0]     fifo_dout;
  logic [CW-1:0]  fifo_count;
  logic           busy;
  logic [31:0]    rd_next;
  logic           unused_wdata;

  uart_tx_state_t state_reg, state_next;
  logic [15:0]    cnt_reg, cnt_next;
  logic [15:0]    shadow_div_reg, shadow_div_next;
  logic [2:0]     bit_idx_reg, bit_idx_next;
  logic [7:0]     shift_reg, shift_next;
  logic           start_frame;
`ifdef UART_TX_PARITY_EN
  logic           parity_reg, parity_next;
`endif

  assign ofs          = IOBUS_ADDR[3:0];
  assign sel          = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign wr_txdata    = IOBUS_WR && sel && (ofs == TXDATA_OFS);
  assign wr_status    = IOBUS_WR && sel && (ofs == STATUS_OFS);
  assign wr_div       = IOBUS_WR && sel && (ofs == DIV_OFS);
  assign unused_wdata = ^IOBUS_OUT[31:16];

  iobus_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (IOBUS_OUT[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A push that lands on a full FIFO is dropped unless the FSM pops in the same cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_reg <= RESET_DIV;
      ovf_reg <= 1'b0;
    end else begin
      if (wr_div) div_reg <= clamp_div(IOBUS_OUT[15:0]);
      if (wr_status)                                 ovf_reg <= 1'b0;
      else if (wr_txdata && fifo_full && !fifo_pop)  ovf_reg <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_reg        <= RESET_DIV;
      shadow_div_reg <= RESET_DIV;
      bit_idx_reg    <= 3'd0;
      shift_reg      <= 8'd0;
`ifdef UART_TX_PARITY_EN
      parity_reg     <= 1'b0;
`endif
    end else begin
      cnt_reg        <= cnt_next;
      shadow_div_reg <= shadow_div_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
`ifdef UART_TX_PARITY_EN
      parity_reg     <= parity_next;
`endif
    end
  end

  // Every non-idle state lasts shadow_div cycles; cnt_reg == 1 marks the bit boundary.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    shadow_div_next = shadow_div_reg;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    start_frame     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next     = parity_reg;
`endif
    case (state_reg)
      S_IDLE: start_frame = !fifo_empty;
      default: begin
        if (cnt_reg != 16'd1) begin
          cnt_next = cnt_reg - 16'd1;
        end else begin
          cnt_next = shadow_div_reg;
          case (state_reg)
            S_START: state_next = S_DATA;
            S_DATA: begin
              shift_next   = {1'b0, shift_reg[7:1]};
              bit_idx_next = bit_idx_reg + 3'd1;
`ifdef UART_TX_PARITY_EN
              if (bit_idx_reg == 3'd7) state_next = S_PARITY;
`else
              if (bit_idx_reg == 3'd7) state_next = S_STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: state_next = S_STOP;
`endif
            S_STOP: begin
              if (!fifo_empty) start_frame = 1'b1;
              else             state_next  = S_IDLE;
            end
            default: state_next = S_IDLE;
          endcase
        end
      end
    endcase

    // Frame start snapshots the divisor so later DIV writes only affect the next frame.
    if (start_frame) begin
      state_next      = S_START;
      cnt_next        = div_reg;
      shadow_div_next = div_reg;
      bit_idx_next    = 3'd0;
      shift_next      = fifo_dout;
`ifdef UART_TX_PARITY_EN
      parity_next     = ^fifo_dout;
`endif
    end
  end

  assign fifo_pop = start_frame;

  always_comb begin
    tx   = 1'b1;
    busy = (state_reg != S_IDLE);
    case (state_reg)
      S_START:  tx = 1'b0;
      S_DATA:   tx = shift_reg[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx = parity_reg;
`endif
      default:  tx = 1'b1;
    endcase
  end

  always_comb begin
    rd_next = '0;
    if (sel) begin
      case (ofs)
        STATUS_OFS: begin
          rd_next[STAT_BUSY]       = busy;
          rd_next[STAT_FULL]       = fifo_full;
          rd_next[STAT_EMPTY]      = fifo_empty;
          rd_next[STAT_OVF]        = ovf_reg;
          rd_next[STAT_CNT +: CW]  = fifo_count;
        end
        DIV_OFS: rd_next[15:0] = div_reg;
        default: rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) rd_data <= '0;
    else       rd_data <= rd_next;
  end

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Self-checking bench for iobus_uart_tx: bus tasks, a serial-line decoder and a byte scoreboard.
module tb_iobus_uart_tx;

  localparam logic [31:0] BASE  = 32'h1100_0100;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_DIV = BASE + 32'h8;
  localparam logic [31:0] A_RSV = BASE + 32'hC;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] IOBUS_ADDR = '0;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] rd_data;
  logic        tx;

  iobus_uart_tx dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .rd_data    (rd_data),
    .tx         (tx)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; int div; } exp_t;
  typedef struct {
    logic [7:0] data;
    logic       start_b;
    logic       stop_b;
    logic       par_b;
    logic       glitch;
    int         start_cyc;
  } cap_t;

  exp_t exp_q[$];
  int   mon_div_q[$];
  cap_t cap_q[$];
  int   checks = 0;
  int   errors = 0;

  // Line decoder: a low level while idle starts a frame; each bit must hold for its whole span.
  task automatic capture_frame();
    cap_t        c;
    logic [FB-1:0] bits;
    logic        v;
    int          d;
    c.start_cyc = cyc;
    c.glitch    = 1'b0;
    bits        = '0;
    d = (mon_div_q.size() > 0) ? mon_div_q.pop_front() : 1;
    for (int i = 0; i < FB; i++) begin
      for (int j = 0; j < d; j++) begin
        if (i != 0 || j != 0) @(negedge CLK);
        v = tx;
        if (j == 0) bits[i] = v;
        else if (v !== bits[i]) c.glitch = 1'b1;
      end
    end
    c.start_b = bits[0];
    c.data    = bits[8:1];
`ifdef UART_TX_PARITY_EN
    c.par_b   = bits[9];
`else
    c.par_b   = 1'b0;
`endif
    c.stop_b  = bits[FB-1];
    cap_q.push_back(c);
  endtask

  initial begin : line_monitor
    forever begin
      @(negedge CLK);
      if (tx === 1'b0) capture_frame();
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int wcyc);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    @(posedge CLK);
    #1;
    wcyc     = cyc;
    IOBUS_WR = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    IOBUS_ADDR = a;
    IOBUS_WR   = 1'b0;
    @(posedge CLK);
    #1;
    d = rd_data;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int div, output int wcyc);
    exp_t e;
    e.data = b;
    e.div  = div;
    exp_q.push_back(e);
    mon_div_q.push_back(div);
    bus_write(A_TX, {24'd0, b}, wcyc);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (cap_q.size() < n && t < budget) begin
      @(posedge CLK);
      t++;
    end
    #1;
    checks++;
    if (cap_q.size() < n) begin
      errors++;
      $display("FAIL frame_timeout: got %0d frames required %0d", cap_q.size(), n);
    end
  endtask

  task automatic scoreboard_drain(input string name, input int n, input bit gapless,
                                  output int first_start);
    cap_t c;
    exp_t e;
    int   prev_start = 0;
    int   prev_div = 0;
    first_start = -1;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (cap_q.size() == 0 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s_frame%0d_present: got %0d captured, %0d expected left", name, k,
                 cap_q.size(), exp_q.size());
        return;
      end
      c = cap_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if ({c.start_b, c.stop_b, c.glitch, c.data} !== {1'b0, 1'b1, 1'b0, e.data}) begin
        errors++;
        $display("FAIL %s_frame%0d: got start=%b stop=%b glitch=%b data=%h required 0 1 0 %h",
                 name, k, c.start_b, c.stop_b, c.glitch, c.data, e.data);
      end
`ifdef UART_TX_PARITY_EN
      checks++;
      if (c.par_b !== ^e.data) begin
        errors++;
        $display("FAIL %s_parity%0d: got %b required %b", name, k, c.par_b, ^e.data);
      end
`endif
      if (k == 0) first_start = c.start_cyc;
      else if (gapless) begin
        checks++;
        if (c.start_cyc !== prev_start + FB * prev_div) begin
          errors++;
          $display("FAIL %s_gap%0d: got start %0d required %0d", name, k, c.start_cyc,
                   prev_start + FB * prev_div);
        end
      end
      prev_start = c.start_cyc;
      prev_div   = e.div;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    RESET = 1'b1;
    idle(3);
    checks++;
    if (rd_data !== 32'd0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: got rd_data=%h tx=%b required 0 1", rd_data, tx);
    end
    RESET = 1'b0;
    bus_read(A_ST, d);
    checks++;
    if (d !== 32'h0000_0004) begin errors++; $display("FAIL reset_status: got %h required 00000004", d); end
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", tx); end
    bus_read(A_DIV, d);
    checks++;
    if (d !== 32'd868) begin errors++; $display("FAIL reset_div: got %0d required 868", d); end
    bus_read(A_RSV, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_reserved: got %h required 0", d); end
    bus_read(A_TX, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_txdata_read: got %h required 0", d); end
  endtask

  task automatic test_window();
    logic [31:0] d;
    int w;
    bus_write(BASE + 32'h10, 32'h55, w);
    bus_write(A_RSV, 32'hFF, w);
    idle(30);
    checks++;
    if (cap_q.size() != 0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL window_nopush: got frames=%0d tx=%b required 0 1", cap_q.size(), tx);
    end
    bus_read(BASE + 32'h10, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL window_read: got %h required 0", d); end
    bus_read(A_ST, d);
    checks++;
    if (d !== 32'h0000_0004) begin errors++; $display("FAIL window_status: got %h required 00000004", d); end
  endtask

  task automatic test_div_reg();
    logic [31:0] d;
    int w;
    bus_write(A_DIV, 32'd0, w);
    bus_read(A_DIV, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL div_zero: got %h required 1", d); end
    bus_write(A_DIV, 32'h0001_2345, w);
    bus_read(A_DIV, d);
    checks++;
    if (d !== 32'h0000_2345) begin errors++; $display("FAIL div_upper: got %h required 00002345", d); end
  endtask

  task automatic test_single_frame();
    logic [31:0] d;
    int w, wtx, first;
    bus_write(A_DIV, 32'd4, w);
    send_byte(8'hA5, 4, wtx);
    bus_read(A_ST, d);
    checks++;
    if (d !== 32'h0000_0100) begin errors++; $display("FAIL single_status_queued: got %h required 00000100", d); end
    bus_read(A_ST, d);
    checks++;
    if (d !== 32'h0000_0005) begin errors++; $display("FAIL single_status_busy: got %h required 00000005", d); end
    wait_frames(1, 200);
    scoreboard_drain("single", 1, 1'b0, first);
    checks++;
    if (first !== wtx + 1) begin errors++; $display("FAIL single_latency: got start %0d required %0d", first, wtx + 1); end
    bus_read(A_ST, d);
    checks++;
    if (d !== 32'h0000_0004 || tx !== 1'b1) begin
      errors++;
      $display("FAIL single_done: got status=%h tx=%b required 00000004 1", d, tx);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    int w, first;
    bus_write(A_DIV, 32'd2, w);
    send_byte(8'h81, 2, w);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) send_byte(8'h10 + 8'(i), 2, w);
      else        bus_write(A_TX, 32'hEE, w);
    end
    bus_read(A_ST, d);
    checks++;
    if (d !== 32'h0000_100B) begin errors++; $display("FAIL ovf_status: got %h required 0000100b", d); end
    bus_write(A_ST, 32'h0, w);
    bus_read(A_ST, d);
    checks++;
    if (d !== 32'h0000_1003) begin errors++; $display("FAIL ovf_clear: got %h required 00001003", d); end
    // This push lands on the pop edge of the next frame, so it must be accepted.
    send_byte(8'h77, 2, w);
    bus_read(A_ST, d);
    checks++;
    if (d !== 32'h0000_1003) begin errors++; $display("FAIL ovf_pushpop_full: got %h required 00001003", d); end
    wait_frames(18, 18 * FB * 2 + 200);
    scoreboard_drain("overflow", 18, 1'b1, first);
    idle(5);
    checks++;
    if (cap_q.size() != 0) begin errors++; $display("FAIL ovf_extra_frames: got %0d required 0", cap_q.size()); end
    bus_read(A_ST, d);
    checks++;
    if (d !== 32'h0000_0004) begin errors++; $display("FAIL ovf_final_status: got %h required 00000004", d); end
  endtask

  task automatic test_div_change();
    int w, first;
    bus_write(A_DIV, 32'd2, w);
    send_byte(8'h3C, 2, w);
    send_byte(8'hC3, 8, w);
    idle(3);
    bus_write(A_DIV, 32'd8, w);
    wait_frames(2, FB * 10 + 200);
    scoreboard_drain("divchange", 2, 1'b1, first);
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    int w, hi_bad;
    bus_write(A_DIV, 32'd4, w);
    send_byte(8'hA5, 4, w);
    send_byte(8'h11, 4, w);
    send_byte(8'h22, 4, w);
    send_byte(8'h33, 4, w);
    idle(7);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL rstmid_data_bit: got %b required 0", tx); end
    RESET = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx_async: got %b required 1", tx); end
    idle(2);
    RESET = 1'b0;
    bus_read(A_ST, d);
    checks++;
    if (d !== 32'h0000_0004) begin errors++; $display("FAIL rstmid_status: got %h required 00000004", d); end
    idle(60);
    cap_q.delete();
    exp_q.delete();
    mon_div_q.delete();
    hi_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (tx !== 1'b1) hi_bad++;
    end
    checks++;
    if (hi_bad != 0 || cap_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_quiet: got %0d low cycles %0d frames required 0 0", hi_bad, cap_q.size());
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_window();
    test_div_reg();
    test_single_frame();
    test_overflow();
    test_div_change();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
